// File: rtl/oc_pattern_gen.sv
// ---------------------------------------------------------------------------
// oc_pattern_gen
//
// Stimulus source for the 3-input ones-counter. A target ones-count is taken
// over a valid/ready request channel, and then every W-bit vector whose
// popcount equals that target is emitted in ascending numeric order, one
// vector per output handshake, with the final vector flagged by out_last.
// A target larger than W produces a single out_none beat with out_vec = 0.
//
// Parameters:
//   W   - vector width (2..8)
//   CW  - width of the count field
//
// Ports:
//   clk        in   clock, all state changes on the rising edge
//   rst        in   synchronous active-high reset
//   req_valid  in   request present
//   req_ready  out  request can be accepted (high only while idle)
//   req_count  in   target ones-count, latched on the request handshake
//   out_valid  out  out_vec / out_last / out_none are valid
//   out_ready  in   consumer accepts the current beat
//   out_vec    out  emitted vector (bit W-1 = a, bit 0 = c when W=3)
//   out_last   out  final beat of the current request
//   out_none   out  no vector has the requested count
//   busy       out  generator is not idle
//   err        out  sticky self-check error
//
// Build option:
//   OC_PATTERN_GEN_CHECK_EN - when defined, a self-checker watches every
//   output handshake and raises err on a wrong popcount, a non-ascending
//   vector or a wrong beat count. When undefined, err is tied to 0.
// ---------------------------------------------------------------------------
module oc_pattern_gen #(
  parameter int W  = 3,
  parameter int CW = $clog2(W + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [CW-1:0] req_count,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_vec,
  output logic          out_last,
  output logic          out_none,
  output logic          busy,
  output logic          err
);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    EMIT
  } state_t;

  localparam logic [W:0] CAND_ONE = {{W{1'b0}}, 1'b1};

  state_t        state, state_nxt;
  logic [CW-1:0] tgt, tgt_nxt;
  logic [W:0]    cand, cand_nxt;
  logic [W-1:0]  vec_nxt;
  logic          last_nxt;
  logic          none_nxt;
  logic          cand_match;
  logic          req_fire;
  logic          out_fire;

  function automatic logic [CW-1:0] popcount(input logic [W-1:0] v);
    logic [CW-1:0] pc;
    pc = '0;
    for (int i = 0; i < W; i++) begin
      pc = pc + CW'(v[i]);
    end
    return pc;
  endfunction

  // Highest vector with t ones: the top t bits set.
  function automatic logic [W-1:0] last_vec(input logic [CW-1:0] t);
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < W; i++) begin
      if ((W - i) <= int'(t)) v[i] = 1'b1;
    end
    return v;
  endfunction

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == EMIT);
  assign req_fire  = req_valid && (state == IDLE);
  assign out_fire  = out_ready && (state == EMIT);

  // The extra top bit of cand only guards against aliasing after a wrap;
  // a candidate with it set is never a legal vector.
  assign cand_match = !cand[W] && (popcount(cand[W-1:0]) == tgt);

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tgt      <= '0;
      cand     <= '0;
      out_vec  <= '0;
      out_last <= 1'b0;
      out_none <= 1'b0;
    end else begin
      state    <= state_nxt;
      tgt      <= tgt_nxt;
      cand     <= cand_nxt;
      out_vec  <= vec_nxt;
      out_last <= last_nxt;
      out_none <= none_nxt;
    end
  end

  // Next-state logic: scan one candidate per cycle, park in EMIT on a match
  // until the consumer takes it, then resume from the vector just emitted.
  always_comb begin
    state_nxt = state;
    tgt_nxt   = tgt;
    cand_nxt  = cand;
    vec_nxt   = out_vec;
    last_nxt  = out_last;
    none_nxt  = out_none;
    case (state)
      IDLE: begin
        if (req_valid) begin
          tgt_nxt  = req_count;
          cand_nxt = '0;
          if (req_count > CW'(W)) begin
            vec_nxt   = '0;
            none_nxt  = 1'b1;
            last_nxt  = 1'b1;
            state_nxt = EMIT;
          end else begin
            state_nxt = SCAN;
          end
        end
      end
      SCAN: begin
        if (cand_match) begin
          vec_nxt   = cand[W-1:0];
          last_nxt  = (cand[W-1:0] == last_vec(tgt));
          none_nxt  = 1'b0;
          state_nxt = EMIT;
        end else begin
          cand_nxt = cand + CAND_ONE;
        end
      end
      EMIT: begin
        if (out_ready) begin
          if (out_last) begin
            state_nxt = IDLE;
          end else begin
            cand_nxt  = {1'b0, out_vec} + CAND_ONE;
            state_nxt = SCAN;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

`ifdef OC_PATTERN_GEN_CHECK_EN
  logic [W-1:0] prev_vec;
  logic         have_prev;
  logic [7:0]   beat_cnt;
  logic         err_q;

  function automatic int binom_f(input int n, input int k);
    int r;
    r = 1;
    for (int i = 0; i < k; i++) begin
      r = r * (n - i) / (i + 1);
    end
    return r;
  endfunction

  // Small constant table of C(W, t) for t = 0..W.
  function automatic logic [7:0] binom_rom(input logic [CW-1:0] t);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i <= W; i++) begin
      if (t == CW'(i)) r = 8'(binom_f(W, i));
    end
    return r;
  endfunction

  // Self-checker: every accepted beat must carry the target popcount, be
  // strictly above the previous beat, and the last beat must close a
  // sequence of exactly C(W, tgt) beats. The error is sticky until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_vec  <= '0;
      have_prev <= 1'b0;
      beat_cnt  <= '0;
      err_q     <= 1'b0;
    end else begin
      if (req_fire) begin
        have_prev <= 1'b0;
        beat_cnt  <= '0;
      end
      if (out_fire) begin
        prev_vec  <= out_vec;
        have_prev <= 1'b1;
        beat_cnt  <= beat_cnt + 8'd1;
        if (!out_none) begin
          if (popcount(out_vec) != tgt) err_q <= 1'b1;
          if (have_prev && (out_vec <= prev_vec)) err_q <= 1'b1;
          if (out_last && ((beat_cnt + 8'd1) != binom_rom(tgt))) err_q <= 1'b1;
        end
      end
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
